// File: rtl/controller_multicycle_rv32i_pkg.sv
// Shared types for the multicycle RV32I controller: ALU ops, FSM states, decoded instruction.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package controller_multicycle_rv32i_pkg;

  typedef enum logic [4:0] {
    AluOp_Unknown = 5'd0,
    AluOp_ADD, AluOp_SUB, AluOp_SLL, AluOp_SLT, AluOp_SLTU,
    AluOp_XOR, AluOp_SRL, AluOp_SRA, AluOp_OR, AluOp_AND,
    AluOp_MUL, AluOp_MULH, AluOp_MULHSU, AluOp_MULHU,
    AluOp_DIV, AluOp_DIVU, AluOp_REM, AluOp_REMU
  } AluOp;

  typedef enum logic [2:0] {
    CtrlState_Fetch, CtrlState_Decode, CtrlState_Exec, CtrlState_Mem,
    CtrlState_Wb, CtrlState_AluWait, CtrlState_Halt
  } CtrlState;

  typedef enum logic [3:0] {
    InstClass_Alu, InstClass_Lui, InstClass_Auipc, InstClass_Branch,
    InstClass_Jal, InstClass_Jalr, InstClass_Fence, InstClass_Load,
    InstClass_Store, InstClass_MulDiv
  } InstClass;

  typedef struct packed {
    InstClass   instClass;
    AluOp       aluOp;
    logic [1:0] operandASel;
    logic       operandBSel;
    logic [1:0] regWrDataSel;
    logic [1:0] pcNextSel;
    logic [1:0] memSize;
    logic       memUnsigned;
    logic [2:0] funct3;
    logic       illegal;
  } DecodedInst;

  // Register write-data, PC and operand selects shared with the single-cycle controller
  localparam logic [1:0] wrSelAlu    = 2'b00;
  localparam logic [1:0] wrSelMem    = 2'b01;
  localparam logic [1:0] wrSelPc4    = 2'b10;
  localparam logic [1:0] pcSelPlus4  = 2'b00;
  localparam logic [1:0] pcSelOffset = 2'b01;
  localparam logic [1:0] pcSelRs1    = 2'b10;
  localparam logic [1:0] opASelRs1   = 2'b00;
  localparam logic [1:0] opASelPc    = 2'b01;
  localparam logic [1:0] opASelZero  = 2'b10;
  localparam logic [1:0] memSizeWord = 2'b10;

  // Base integer op from funct3; alt selects SUB/SRA
  function automatic AluOp aluOpFor(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? AluOp_SUB : AluOp_ADD;
      3'b001:  return AluOp_SLL;
      3'b010:  return AluOp_SLT;
      3'b011:  return AluOp_SLTU;
      3'b100:  return AluOp_XOR;
      3'b101:  return alt ? AluOp_SRA : AluOp_SRL;
      3'b110:  return AluOp_OR;
      default: return AluOp_AND;
    endcase
  endfunction

  function automatic AluOp mulDivOp(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return AluOp_MUL;
      3'b001:  return AluOp_MULH;
      3'b010:  return AluOp_MULHSU;
      3'b011:  return AluOp_MULHU;
      3'b100:  return AluOp_DIV;
      3'b101:  return AluOp_DIVU;
      3'b110:  return AluOp_REM;
      default: return AluOp_REMU;
    endcase
  endfunction

  // Branch condition from funct3 and the datapath comparator flags
  function automatic logic branchTaken(input logic [2:0] funct3, input logic isEq,
                                       input logic isLt, input logic isLtu);
    case (funct3)
      3'b000:  return isEq;
      3'b001:  return !isEq;
      3'b100:  return isLt;
      3'b101:  return !isLt;
      3'b110:  return isLtu;
      3'b111:  return !isLtu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I(+M) decoder: instruction register -> DecodedInst.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the instruction register.
module rv32i_decoder
  import controller_multicycle_rv32i_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] inst,
  output DecodedInst  decoded
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unusedBits;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  // Register indices and immediates belong to the datapath, not the controller
  assign unusedBits = ^{inst[24:15], inst[11:7]};

  // Classify the instruction and pick its ALU op and datapath selects
  always_comb begin
    decoded              = '0;
    decoded.instClass    = InstClass_Alu;
    decoded.aluOp        = AluOp_Unknown;
    decoded.operandASel  = opASelRs1;
    decoded.operandBSel  = 1'b0;
    decoded.regWrDataSel = wrSelAlu;
    decoded.pcNextSel    = pcSelPlus4;
    decoded.memSize      = funct3[1:0];
    decoded.memUnsigned  = funct3[2];
    decoded.funct3       = funct3;
    decoded.illegal      = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          decoded.aluOp = aluOpFor(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          decoded.aluOp = aluOpFor(funct3, 1'b1);
        end else if (ENABLE_M && funct7 == 7'b0000001) begin
          decoded.instClass = InstClass_MulDiv;
          decoded.aluOp     = mulDivOp(funct3);
        end else begin
          decoded.illegal = 1'b1;
        end
      end
      7'b0010011: begin
        decoded.operandBSel = 1'b1;
        if (funct3 == 3'b001) begin
          decoded.aluOp   = AluOp_SLL;
          decoded.illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          decoded.aluOp   = (funct7 == 7'b0100000) ? AluOp_SRA : AluOp_SRL;
          decoded.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end else begin
          decoded.aluOp = aluOpFor(funct3, 1'b0);
        end
      end
      7'b0110111: begin
        decoded.instClass   = InstClass_Lui;
        decoded.aluOp       = AluOp_ADD;
        decoded.operandASel = opASelZero;
        decoded.operandBSel = 1'b1;
      end
      7'b0010111: begin
        decoded.instClass   = InstClass_Auipc;
        decoded.aluOp       = AluOp_ADD;
        decoded.operandASel = opASelPc;
        decoded.operandBSel = 1'b1;
      end
      7'b1101111: begin
        decoded.instClass    = InstClass_Jal;
        decoded.aluOp        = AluOp_ADD;
        decoded.operandASel  = opASelPc;
        decoded.operandBSel  = 1'b1;
        decoded.regWrDataSel = wrSelPc4;
        decoded.pcNextSel    = pcSelOffset;
      end
      7'b1100111: begin
        decoded.instClass    = InstClass_Jalr;
        decoded.aluOp        = AluOp_ADD;
        decoded.operandBSel  = 1'b1;
        decoded.regWrDataSel = wrSelPc4;
        decoded.pcNextSel    = pcSelRs1;
        decoded.illegal      = (funct3 != 3'b000);
      end
      7'b1100011: begin
        // Comparison comes from the datapath flags; the ALU just sees rs1-rs2
        decoded.instClass = InstClass_Branch;
        decoded.aluOp     = AluOp_SUB;
        decoded.illegal   = (funct3[2:1] == 2'b01);
      end
      7'b0000011: begin
        decoded.instClass   = InstClass_Load;
        decoded.aluOp       = AluOp_ADD;
        decoded.operandBSel = 1'b1;
        decoded.illegal     = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      7'b0100011: begin
        decoded.instClass   = InstClass_Store;
        decoded.aluOp       = AluOp_ADD;
        decoded.operandBSel = 1'b1;
        decoded.illegal     = (funct3[2] == 1'b1) || (funct3[1:0] == 2'b11);
      end
      7'b0001111: begin
        decoded.instClass = InstClass_Fence;
        decoded.illegal   = (funct3 != 3'b000);
      end
      // SYSTEM (ECALL/EBREAK/CSR) and unknown opcodes trap
      default: decoded.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/controller_multicycle_rv32i.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with optional M-unit wait and HALT trap.
// Latency: ALU/branch/jump 3, store 4, load 5, M-op 4+busy cycles at zero-wait memory.
// Backpressure: memory requests held until i_MemReady (optional timeout); M-ops wait on i_AluReady.
module controller_multicycle_rv32i
  import controller_multicycle_rv32i_pkg::*;
#(
  parameter bit ENABLE_M    = 1'b0,
  parameter int MEM_TIMEOUT = 0,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1) + 1
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [31:0] i_Inst,
  input  logic        i_IsEQ,
  input  logic        i_IsLT,
  input  logic        i_IsLTU,
  input  logic        i_MemReady,
  input  logic        i_AluReady,
  output logic        o_MemRdEnable,
  output logic        o_MemWrEnable,
  output logic        o_MemAddrSel,
  output logic [1:0]  o_MemSize,
  output logic        o_MemUnsigned,
  output logic        o_IRWrEnable,
  output logic        o_PCWrEnable,
  output logic [1:0]  o_PCNextSel,
  output AluOp        o_AluControl,
  output logic        o_AluStart,
  output logic [1:0]  o_OperandASel,
  output logic        o_OperandBSel,
  output logic        o_RegWrEnable,
  output logic [1:0]  o_RegWrDataSel,
  output logic        o_Retire,
  output logic        o_Illegal,
  output logic        o_BusFault
);

  localparam logic [TMO_W-1:0] tmoLast = TMO_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

  CtrlState         state;
  logic [TMO_W-1:0] waitCount;
  logic             illegalFlag;
  logic             busFaultFlag;
  logic             timeoutHit;
  DecodedInst       dec;

  rv32i_decoder #(.ENABLE_M(ENABLE_M)) decoder (
    .inst    (i_Inst),
    .decoded (dec)
  );

  // The current wait cycle is the last one allowed before a bus fault
  assign timeoutHit = (MEM_TIMEOUT != 0) && (waitCount == tmoLast);

  assign o_Illegal  = illegalFlag;
  assign o_BusFault = busFaultFlag;

  // State sequencing, memory wait counter and sticky trap flags
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state        <= CtrlState_Fetch;
      waitCount    <= '0;
      illegalFlag  <= 1'b0;
      busFaultFlag <= 1'b0;
    end else begin
      case (state)
        CtrlState_Fetch: begin
          if (i_MemReady) begin
            state     <= CtrlState_Decode;
            waitCount <= '0;
          end else if (timeoutHit) begin
            state        <= CtrlState_Halt;
            busFaultFlag <= 1'b1;
          end else if (MEM_TIMEOUT != 0) begin
            waitCount <= waitCount + TMO_W'(1);
          end
        end
        CtrlState_Decode: begin
          waitCount <= '0;
          if (dec.illegal) begin
            state       <= CtrlState_Halt;
            illegalFlag <= 1'b1;
          end else begin
            state <= CtrlState_Exec;
          end
        end
        CtrlState_Exec: begin
          waitCount <= '0;
          case (dec.instClass)
            InstClass_Load, InstClass_Store: state <= CtrlState_Mem;
            InstClass_MulDiv:                state <= CtrlState_AluWait;
            default:                         state <= CtrlState_Fetch;
          endcase
        end
        CtrlState_Mem: begin
          if (i_MemReady) begin
            state     <= (dec.instClass == InstClass_Store) ? CtrlState_Fetch : CtrlState_Wb;
            waitCount <= '0;
          end else if (timeoutHit) begin
            state        <= CtrlState_Halt;
            busFaultFlag <= 1'b1;
          end else if (MEM_TIMEOUT != 0) begin
            waitCount <= waitCount + TMO_W'(1);
          end
        end
        CtrlState_Wb: begin
          waitCount <= '0;
          state     <= CtrlState_Fetch;
        end
        CtrlState_AluWait: begin
          waitCount <= '0;
          if (i_AluReady) state <= CtrlState_Fetch;
        end
        default: begin
          waitCount <= '0;
          state     <= CtrlState_Halt;
        end
      endcase
    end
  end

  // Datapath controls from current state and decoded IR; all forced low while in reset
  always_comb begin
    o_MemRdEnable  = 1'b0;
    o_MemWrEnable  = 1'b0;
    o_MemAddrSel   = 1'b0;
    o_MemSize      = 2'b00;
    o_MemUnsigned  = 1'b0;
    o_IRWrEnable   = 1'b0;
    o_PCWrEnable   = 1'b0;
    o_PCNextSel    = pcSelPlus4;
    o_AluControl   = AluOp_Unknown;
    o_AluStart     = 1'b0;
    o_OperandASel  = opASelRs1;
    o_OperandBSel  = 1'b0;
    o_RegWrEnable  = 1'b0;
    o_RegWrDataSel = wrSelAlu;
    o_Retire       = 1'b0;
    if (i_Reset) begin
      case (state)
        CtrlState_Fetch: begin
          o_MemRdEnable = 1'b1;
          o_MemSize     = memSizeWord;
          o_IRWrEnable  = i_MemReady;
        end
        CtrlState_Exec: begin
          o_AluControl  = dec.aluOp;
          o_OperandASel = dec.operandASel;
          o_OperandBSel = dec.operandBSel;
          case (dec.instClass)
            InstClass_Alu, InstClass_Lui, InstClass_Auipc, InstClass_Jal, InstClass_Jalr: begin
              o_RegWrEnable  = 1'b1;
              o_RegWrDataSel = dec.regWrDataSel;
              o_PCWrEnable   = 1'b1;
              o_PCNextSel    = dec.pcNextSel;
              o_Retire       = 1'b1;
            end
            InstClass_Branch: begin
              o_PCWrEnable = 1'b1;
              o_PCNextSel  = branchTaken(dec.funct3, i_IsEQ, i_IsLT, i_IsLTU) ? pcSelOffset : pcSelPlus4;
              o_Retire     = 1'b1;
            end
            InstClass_Fence: begin
              o_PCWrEnable = 1'b1;
              o_Retire     = 1'b1;
            end
            InstClass_MulDiv: o_AluStart = 1'b1;
            default: ;
          endcase
        end
        CtrlState_Mem: begin
          // Keep the address computation alive for the whole access
          o_AluControl  = dec.aluOp;
          o_OperandASel = dec.operandASel;
          o_OperandBSel = dec.operandBSel;
          o_MemAddrSel  = 1'b1;
          o_MemSize     = dec.memSize;
          o_MemUnsigned = dec.memUnsigned;
          if (dec.instClass == InstClass_Store) begin
            o_MemWrEnable = 1'b1;
            o_PCWrEnable  = i_MemReady;
            o_Retire      = i_MemReady;
          end else begin
            o_MemRdEnable = 1'b1;
          end
        end
        CtrlState_Wb: begin
          o_RegWrEnable  = 1'b1;
          o_RegWrDataSel = wrSelMem;
          o_PCWrEnable   = 1'b1;
          o_Retire       = 1'b1;
        end
        CtrlState_AluWait: begin
          o_AluControl  = dec.aluOp;
          o_OperandASel = dec.operandASel;
          o_OperandBSel = dec.operandBSel;
          if (i_AluReady) begin
            o_RegWrEnable = 1'b1;
            o_PCWrEnable  = 1'b1;
            o_Retire      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_multicycle_rv32i.sv
// Scoreboard bench: dutA (no M, no timeout) and dutB (M enabled, timeout 4).
// Expected retire events are queued at issue time and checked by per-DUT monitors.
// Direct checks cover reset, traps and request hold/drop behaviour.
module tb_controller_multicycle_rv32i;
  import controller_multicycle_rv32i_pkg::*;

  typedef struct {
    string      name;
    logic       regWr;
    logic [1:0] wrSel;
    logic       pcWr;
    logic [1:0] pcSel;
    logic       chkAlu;
    AluOp       aluOp;
    logic       opB;
    int         expCyc;
  } expRec_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  expRec_t qA[$];
  expRec_t qB[$];

  logic        isEQ, isLT, isLTU;
  logic        rstA, rdyA, aluRdyA, rstB, rdyB, aluRdyB;
  logic [31:0] instA, instB;

  logic rdA, wrA, addrSelA, unsA, irWrA, pcWrA, startA, opBA, regWrA, retA, illA, bfA;
  logic [1:0] sizeA, pcSelA, opASelA, wrSelA;
  AluOp aluA;
  logic rdB, wrB, addrSelB, unsB, irWrB, pcWrB, startB, opBB, regWrB, retB, illB, bfB;
  logic [1:0] sizeB, pcSelB, opASelB, wrSelB;
  AluOp aluB;

  int memRdCntA = 0, regWrCntA = 0, startCntB = 0, snap;

  controller_multicycle_rv32i #(.ENABLE_M(1'b0), .MEM_TIMEOUT(0)) dutA (
    .i_Clock(clk), .i_Reset(rstA), .i_Inst(instA), .i_IsEQ(isEQ), .i_IsLT(isLT), .i_IsLTU(isLTU),
    .i_MemReady(rdyA), .i_AluReady(aluRdyA), .o_MemRdEnable(rdA), .o_MemWrEnable(wrA),
    .o_MemAddrSel(addrSelA), .o_MemSize(sizeA), .o_MemUnsigned(unsA), .o_IRWrEnable(irWrA),
    .o_PCWrEnable(pcWrA), .o_PCNextSel(pcSelA), .o_AluControl(aluA), .o_AluStart(startA),
    .o_OperandASel(opASelA), .o_OperandBSel(opBA), .o_RegWrEnable(regWrA), .o_RegWrDataSel(wrSelA),
    .o_Retire(retA), .o_Illegal(illA), .o_BusFault(bfA));

  controller_multicycle_rv32i #(.ENABLE_M(1'b1), .MEM_TIMEOUT(4)) dutB (
    .i_Clock(clk), .i_Reset(rstB), .i_Inst(instB), .i_IsEQ(isEQ), .i_IsLT(isLT), .i_IsLTU(isLTU),
    .i_MemReady(rdyB), .i_AluReady(aluRdyB), .o_MemRdEnable(rdB), .o_MemWrEnable(wrB),
    .o_MemAddrSel(addrSelB), .o_MemSize(sizeB), .o_MemUnsigned(unsB), .o_IRWrEnable(irWrB),
    .o_PCWrEnable(pcWrB), .o_PCNextSel(pcSelB), .o_AluControl(aluB), .o_AluStart(startB),
    .o_OperandASel(opASelB), .o_OperandBSel(opBB), .o_RegWrEnable(regWrB), .o_RegWrDataSel(wrSelB),
    .o_Retire(retB), .o_Illegal(illB), .o_BusFault(bfB));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdA && addrSelA) memRdCntA <= memRdCntA + 1;
    if (regWrA) regWrCntA <= regWrCntA + 1;
    if (startB) startCntB <= startCntB + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic checkRetire(input int which, input logic regWr, input logic [1:0] wrSel,
                             input logic pcWr, input logic [1:0] pcSel, input AluOp aluOp,
                             input logic opB);
    expRec_t e;
    if ((which == 0 && qA.size() == 0) || (which == 1 && qB.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL retire%0d: unexpected retire at cycle %0d, expected none", which, cyc);
      return;
    end
    if (which == 0) e = qA.pop_front();
    else e = qB.pop_front();
    check({e.name, ".cycle"}, cyc, e.expCyc);
    check({e.name, ".regWr"}, 32'(regWr), 32'(e.regWr));
    check({e.name, ".wrSel"}, 32'(wrSel), 32'(e.wrSel));
    check({e.name, ".pcWr"}, 32'(pcWr), 32'(e.pcWr));
    check({e.name, ".pcSel"}, 32'(pcSel), 32'(e.pcSel));
    if (e.chkAlu) begin
      check({e.name, ".aluOp"}, 32'(aluOp), 32'(e.aluOp));
      check({e.name, ".opB"}, 32'(opB), 32'(e.opB));
    end
  endtask

  // Monitors: every retire pulse is matched against the next queued expectation
  always @(negedge clk) if (retA) checkRetire(0, regWrA, wrSelA, pcWrA, pcSelA, aluA, opBA);
  always @(negedge clk) if (retB) checkRetire(1, regWrB, wrSelB, pcWrB, pcSelB, aluB, opBB);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected retire, then drive one instruction cycle by cycle (bit c = cycle c+1)
  task automatic issue(input int which, input string name, input logic [31:0] inst,
                       input logic [15:0] rdyPat, input logic [15:0] aluPat, input int lat,
                       input logic regWr, input logic [1:0] wrSel, input logic [1:0] pcSel,
                       input logic chkAlu, input AluOp aluOp, input logic opB);
    expRec_t e;
    e.name = name; e.regWr = regWr; e.wrSel = wrSel; e.pcWr = 1'b1; e.pcSel = pcSel;
    e.chkAlu = chkAlu; e.aluOp = aluOp; e.opB = opB; e.expCyc = cyc + lat - 1;
    if (which == 0) qA.push_back(e);
    else qB.push_back(e);
    for (int c = 0; c < lat; c++) begin
      if (which == 0) begin
        instA = inst; rdyA = rdyPat[c]; aluRdyA = aluPat[c];
      end else begin
        instB = inst; rdyB = rdyPat[c]; aluRdyB = aluPat[c];
      end
      tick();
    end
  endtask

  initial begin
    rstA = 1'b0; rstB = 1'b0; instA = '0; instB = '0;
    rdyA = 1'b0; rdyB = 1'b0; aluRdyA = 1'b0; aluRdyB = 1'b0;
    isEQ = 1'b0; isLT = 1'b0; isLTU = 1'b0;
    repeat (3) tick();

    // Reset state: every control low, ALU op unknown
    check("rstA.ctrl", 32'({rdA, wrA, addrSelA, sizeA, unsA, irWrA, pcWrA, pcSelA, startA,
                            opASelA, opBA, regWrA, wrSelA, retA, illA, bfA}), 32'd0);
    check("rstA.alu", 32'(aluA), 32'(AluOp_Unknown));
    check("rstB.ctrl", 32'({rdB, wrB, addrSelB, sizeB, unsB, irWrB, pcWrB, pcSelB, startB,
                            opASelB, opBB, regWrB, wrSelB, retB, illB, bfB}), 32'd0);
    check("rstB.alu", 32'(aluB), 32'(AluOp_Unknown));

    rstA = 1'b1; rdyA = 1'b1;
    #1;
    check("A.firstFetch.rd", 32'(rdA), 32'd1);
    check("A.firstFetch.addrSel", 32'(addrSelA), 32'd0);

    issue(0, "addi", 32'h00500093, 16'hFFFF, 16'h0, 3, 1'b1, wrSelAlu, pcSelPlus4, 1'b1, AluOp_ADD, 1'b1);

    snap = memRdCntA;
    issue(0, "lwWait", 32'h0040A103, 16'h0067, 16'h0, 7, 1'b1, wrSelMem, pcSelPlus4, 1'b0, AluOp_Unknown, 1'b0);
    check("lwWait.rdHeld", memRdCntA - snap, 32'd3);

    isLT = 1'b1; isLTU = 1'b0;
    issue(0, "bgeuTaken", 32'h0020F463, 16'hFFFF, 16'h0, 3, 1'b0, wrSelAlu, pcSelOffset, 1'b0, AluOp_Unknown, 1'b0);
    isLTU = 1'b1;
    issue(0, "bgeuNotTaken", 32'h0020F463, 16'hFFFF, 16'h0, 3, 1'b0, wrSelAlu, pcSelPlus4, 1'b0, AluOp_Unknown, 1'b0);

    // Store stuck in MEM, then reset mid-access
    instA = 32'h0020A423; rdyA = 1'b1;
    repeat (3) tick();
    rdyA = 1'b0;
    @(negedge clk);
    check("sw.wrEnable", 32'(wrA), 32'd1);
    check("sw.addrSel", 32'(addrSelA), 32'd1);
    check("sw.size", 32'(sizeA), 32'(2'b10));
    #2 rstA = 1'b0;
    #1;
    check("sw.rstDropsWr", 32'(wrA), 32'd0);
    check("sw.rstNoRd", 32'(rdA), 32'd0);
    tick();
    check("sw.rstNoPcWr", 32'(pcWrA), 32'd0);
    rstA = 1'b1; rdyA = 1'b1;
    #1;
    check("sw.freshFetch.rd", 32'(rdA), 32'd1);
    check("sw.freshFetch.addrSel", 32'(addrSelA), 32'd0);
    issue(0, "addiAfterRst", 32'h00500093, 16'hFFFF, 16'h0, 3, 1'b1, wrSelAlu, pcSelPlus4, 1'b1, AluOp_ADD, 1'b1);

    // MUL without the M extension traps
    snap = regWrCntA;
    instA = 32'h02208033; rdyA = 1'b1;
    repeat (2) tick();
    check("mulIllegal.flag", 32'(illA), 32'd1);
    check("mulIllegal.noRd", 32'(rdA), 32'd0);
    repeat (4) tick();
    check("mulIllegal.noRegWr", regWrCntA - snap, 32'd0);
    check("mulIllegal.sticky", 32'(illA), 32'd1);
    rstA = 1'b0;
    #1;
    check("mulIllegal.rstClears", 32'(illA), 32'd0);

    // dutB: ready on the 4th fetch cycle beats the 4-cycle timeout
    tick();
    rstB = 1'b1;
    issue(1, "addiLateReady", 32'h00500093, 16'hFFF8, 16'h0, 6, 1'b1, wrSelAlu, pcSelPlus4, 1'b1, AluOp_ADD, 1'b1);
    check("addiLateReady.noFault", 32'(bfB), 32'd0);

    snap = startCntB;
    issue(1, "mul", 32'h02208033, 16'hFFFF, 16'h0020, 6, 1'b1, wrSelAlu, pcSelPlus4, 1'b1, AluOp_MUL, 1'b0);
    check("mul.startPulses", startCntB - snap, 32'd1);

    // Fetch never ready: fault on the 4th waiting cycle
    rdyB = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("tmo.cycle4.rd", 32'(rdB), 32'd1);
    check("tmo.cycle4.fault", 32'(bfB), 32'd0);
    tick();
    check("tmo.halt.rd", 32'(rdB), 32'd0);
    check("tmo.halt.fault", 32'(bfB), 32'd1);
    rdyB = 1'b1;
    repeat (3) tick();
    check("tmo.stays.rd", 32'(rdB), 32'd0);
    check("tmo.stays.irWr", 32'(irWrB), 32'd0);
    check("tmo.stays.fault", 32'(bfB), 32'd1);

    check("qA.drained", qA.size(), 32'd0);
    check("qB.drained", qB.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
